// File: rtl/timer_pkg.sv
// Shared encodings and BCD helpers for the mm:ss countdown timer.
package timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    localparam logic [3:0] SEC10_MAX = 4'd5;
    localparam logic [3:0] MIN10_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef struct packed {
        logic inc_min;
        logic inc_sec;
        logic dec_1s;
        logic zero;
    } core_cmd_t;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d,
                                           input logic [3:0] max);
        return (d == max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_mmss_core.sv
// Four BCD digit registers for mm:ss with per-digit inc/dec arithmetic.
module bcd_mmss_core
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  core_cmd_t  cmd_i,
    output logic [3:0] min10_o,
    output logic [3:0] min1_o,
    output logic [3:0] sec10_o,
    output logic [3:0] sec1_o,
    output logic       is_zero_o,
    output logic       next_is_zero_o
);

    logic [3:0] min10_q, min1_q, sec10_q, sec1_q;
    logic [3:0] min10_d, min1_d, sec10_d, sec1_d;

    always_comb begin
        min10_d = min10_q;
        min1_d  = min1_q;
        sec10_d = sec10_q;
        sec1_d  = sec1_q;
        if (cmd_i.zero) begin
            min10_d = 4'd0;
            min1_d  = 4'd0;
            sec10_d = 4'd0;
            sec1_d  = 4'd0;
        end else if (cmd_i.inc_min) begin
            min1_d = bcd_inc(min1_q, DIGIT_MAX);
            if (min1_q == DIGIT_MAX)
                min10_d = bcd_inc(min10_q, MIN10_MAX);
        end else if (cmd_i.inc_sec) begin
            sec1_d = bcd_inc(sec1_q, DIGIT_MAX);
            if (sec1_q == DIGIT_MAX)
                sec10_d = bcd_inc(sec10_q, SEC10_MAX);
        end else if (cmd_i.dec_1s) begin
            // Borrow ripples digit by digit; 00:00 simply holds.
            if (sec1_q != 4'd0) begin
                sec1_d = sec1_q - 4'd1;
            end else if (sec10_q != 4'd0) begin
                sec10_d = sec10_q - 4'd1;
                sec1_d  = DIGIT_MAX;
            end else if (min1_q != 4'd0) begin
                min1_d  = min1_q - 4'd1;
                sec10_d = SEC10_MAX;
                sec1_d  = DIGIT_MAX;
            end else if (min10_q != 4'd0) begin
                min10_d = min10_q - 4'd1;
                min1_d  = DIGIT_MAX;
                sec10_d = SEC10_MAX;
                sec1_d  = DIGIT_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            min10_q <= 4'd0;
            min1_q  <= 4'd0;
            sec10_q <= 4'd0;
            sec1_q  <= 4'd0;
        end else begin
            min10_q <= min10_d;
            min1_q  <= min1_d;
            sec10_q <= sec10_d;
            sec1_q  <= sec1_d;
        end
    end

    assign min10_o = min10_q;
    assign min1_o  = min1_q;
    assign sec10_o = sec10_q;
    assign sec1_o  = sec1_q;

    assign is_zero_o = (min10_q == 4'd0) && (min1_q == 4'd0) &&
                       (sec10_q == 4'd0) && (sec1_q == 4'd0);

    assign next_is_zero_o = (min10_q == 4'd0) && (min1_q == 4'd0) &&
                            (sec10_q == 4'd0) && (sec1_q == 4'd1);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer FSM: button priority decode, tick handling, alarm timeout.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int ALARM_SEC = 5
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       tick_sec,
    input  logic       btn_start,
    input  logic       btn_inc_min,
    input  logic       btn_inc_sec,
    input  logic       btn_clear,
    output logic [3:0] min10,
    output logic [3:0] min1,
    output logic [3:0] sec10,
    output logic [3:0] sec1,
    output logic       running,
    output logic       alarm,
    output logic       done
);

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_SEC - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       running_q, alarm_q;
    logic       is_zero, next_is_zero;
    logic       can_set;
    core_cmd_t  cmd;

    assign can_set = (state_q == ST_IDLE) || (state_q == ST_PAUSE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        cmd     = '0;
        // Only the highest-priority event acts; the rest are dropped.
        if (btn_clear) begin
            cmd.zero = 1'b1;
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
        end else if (btn_start) begin
            case (state_q)
                ST_IDLE:  if (!is_zero) state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = is_zero ? ST_IDLE : ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end else if (btn_inc_min) begin
            cmd.inc_min = can_set;
        end else if (btn_inc_sec) begin
            cmd.inc_sec = can_set;
        end else if (tick_sec) begin
            case (state_q)
                ST_RUN: begin
                    cmd.dec_1s = 1'b1;
                    if (next_is_zero) begin
                        state_d = ST_ALARM;
                        done_d  = 1'b1;
                        cnt_d   = 4'd0;
                    end
                end
                ST_ALARM: begin
                    if (cnt_q == ALARM_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            alarm_q   <= (state_d == ST_ALARM);
        end
    end

    bcd_mmss_core u_core (
        .clk            (clk),
        .reset_p        (reset_p),
        .cmd_i          (cmd),
        .min10_o        (min10),
        .min1_o         (min1),
        .sec10_o        (sec10),
        .sec1_o         (sec1),
        .is_zero_o      (is_zero),
        .next_is_zero_o (next_is_zero)
    );

    assign running = running_q;
    assign alarm   = alarm_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench: directed vector table, corner sequences, randomized model compare.
module tb_countdown_timer_ctrl;

    localparam int ALARM_SEC = 5;

    logic       clk = 1'b0;
    logic       reset_p = 1'b0;
    logic       tick_sec = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_inc_min = 1'b0;
    logic       btn_inc_sec = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] min10, min1, sec10, sec1;
    logic       running, alarm, done;

    countdown_timer_ctrl #(.ALARM_SEC(ALARM_SEC)) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .tick_sec    (tick_sec),
        .btn_start   (btn_start),
        .btn_inc_min (btn_inc_min),
        .btn_inc_sec (btn_inc_sec),
        .btn_clear   (btn_clear),
        .min10       (min10),
        .min1        (min1),
        .sec10       (sec10),
        .sec1        (sec1),
        .running     (running),
        .alarm       (alarm),
        .done        (done)
    );

    always #4 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        bit c, s, im, is, tk;
        logic [15:0] d;
        bit r, a, dn;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    task automatic expect_out(input string nm, input logic [15:0] d,
                              input bit r, input bit a, input bit dn);
        chk({nm, " digits"}, 32'({min10, min1, sec10, sec1}), 32'(d));
        chk({nm, " running"}, 32'(running), 32'(r));
        chk({nm, " alarm"}, 32'(alarm), 32'(a));
        chk({nm, " done"}, 32'(done), 32'(dn));
    endtask

    task automatic cyc(input bit c, input bit s, input bit im,
                       input bit is, input bit tk, input bit rs);
        @(negedge clk);
        btn_clear   = c;
        btn_start   = s;
        btn_inc_min = im;
        btn_inc_sec = is;
        tick_sec    = tk;
        reset_p     = rs;
        @(posedge clk);
        #1;
        btn_clear   = 1'b0;
        btn_start   = 1'b0;
        btn_inc_min = 1'b0;
        btn_inc_sec = 1'b0;
        tick_sec    = 1'b0;
        reset_p     = 1'b0;
    endtask

    task automatic add(input bit c, input bit s, input bit im, input bit is,
                       input bit tk, input logic [15:0] d, input bit r,
                       input bit a, input bit dn);
        vec_t v;
        v.c = c; v.s = s; v.im = im; v.is = is; v.tk = tk;
        v.d = d; v.r = r; v.a = a; v.dn = dn;
        tbl.push_back(v);
    endtask

    task automatic set_time(input int m, input int s);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < m; i++) cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < s; i++) cyc(0, 0, 0, 1, 0, 0);
    endtask

    // Reference model: whole minutes/seconds as integers.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;
    int m_mm, m_ss, m_st, m_acnt;
    bit m_done;

    task automatic model_step(input bit c, input bit s, input bit im,
                              input bit is, input bit tk);
        int t;
        t = m_mm * 60 + m_ss;
        m_done = 0;
        if (c) begin
            m_st = M_IDLE; m_mm = 0; m_ss = 0; m_acnt = 0;
        end else if (s) begin
            if (m_st == M_IDLE) begin
                if (t > 0) m_st = M_RUN;
            end else if (m_st == M_RUN) m_st = M_PAUSE;
            else if (m_st == M_PAUSE) m_st = (t > 0) ? M_RUN : M_IDLE;
            else m_st = M_IDLE;
        end else if (im) begin
            if (m_st == M_IDLE || m_st == M_PAUSE) m_mm = (m_mm + 1) % 60;
        end else if (is) begin
            if (m_st == M_IDLE || m_st == M_PAUSE) m_ss = (m_ss + 1) % 60;
        end else if (tk) begin
            if (m_st == M_RUN) begin
                t = t - 1;
                m_mm = t / 60;
                m_ss = t % 60;
                if (t == 0) begin
                    m_st = M_ALARM; m_done = 1; m_acnt = 0;
                end
            end else if (m_st == M_ALARM) begin
                m_acnt++;
                if (m_acnt == ALARM_SEC) m_st = M_IDLE;
            end
        end
    endtask

    function automatic logic [15:0] model_dig();
        return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
    endfunction

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        expect_out("reset", 16'h0000, 0, 0, 0);

        //   c  s im is tk  digits   r  a dn
        add(0, 0, 1, 0, 0, 16'h0100, 0, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0200, 0, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0300, 0, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0301, 0, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0302, 0, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0303, 0, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0304, 0, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0305, 0, 0, 0);
        add(0, 0, 0, 0, 1, 16'h0305, 0, 0, 0);
        add(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0001, 0, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0002, 0, 0, 0);
        add(0, 1, 0, 0, 0, 16'h0002, 1, 0, 0);
        add(0, 0, 0, 0, 1, 16'h0001, 1, 0, 0);
        add(0, 0, 0, 0, 1, 16'h0000, 0, 1, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
        add(0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
        add(0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
        add(0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
        add(0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0100, 0, 0, 0);
        add(0, 1, 0, 0, 0, 16'h0100, 1, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0100, 1, 0, 0);
        add(0, 0, 0, 0, 1, 16'h0059, 1, 0, 0);
        add(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0001, 0, 0, 0);
        add(0, 1, 0, 0, 0, 16'h0001, 1, 0, 0);
        add(0, 0, 0, 0, 1, 16'h0000, 0, 1, 1);
        add(0, 1, 0, 0, 1, 16'h0000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].c, tbl[i].s, tbl[i].im, tbl[i].is, tbl[i].tk, 0);
            expect_out($sformatf("vec%0d", i), tbl[i].d,
                       tbl[i].r, tbl[i].a, tbl[i].dn);
        end

        set_time(10, 0);
        expect_out("set 10:00", 16'h1000, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        expect_out("borrow 10:00", 16'h0959, 1, 0, 0);

        set_time(0, 10);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        expect_out("borrow 00:10", 16'h0009, 1, 0, 0);

        set_time(0, 30);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        expect_out("pause w/ tick", 16'h0030, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        expect_out("pause ticks", 16'h0030, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        expect_out("pause inc", 16'h0031, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        expect_out("resume", 16'h0031, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        expect_out("resume tick", 16'h0030, 1, 0, 0);

        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        expect_out("start at zero", 16'h0000, 0, 0, 0);
        for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0, 0);
        expect_out("sec 59", 16'h0059, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        expect_out("sec wrap", 16'h0000, 0, 0, 0);

        set_time(0, 59);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        expect_out("pause wrap", 16'h0000, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        expect_out("pause start zero", 16'h0000, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        expect_out("idle tick", 16'h0000, 0, 0, 0);

        set_time(0, 5);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        expect_out("clear+start", 16'h0000, 0, 0, 0);

        set_time(2, 0);
        cyc(0, 1, 0, 0, 0, 0);
        expect_out("run 02:00", 16'h0200, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        expect_out("reset in run", 16'h0000, 0, 0, 0);

        cyc(0, 0, 0, 0, 0, 1);
        m_mm = 0; m_ss = 0; m_st = M_IDLE; m_acnt = 0; m_done = 0;
        for (int i = 0; i < 4000; i++) begin
            bit c, s, im, is, tk;
            c  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 11) == 0);
            im = ($urandom_range(0, 19) == 0);
            is = ($urandom_range(0, 5) == 0);
            tk = ($urandom_range(0, 2) == 0);
            cyc(c, s, im, is, tk, 0);
            model_step(c, s, im, is, tk);
            expect_out($sformatf("rand%0d", i), model_dig(),
                       m_st == M_RUN, m_st == M_ALARM, m_done);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
